// File: rtl/uart_spi_bridge.sv
// uart_spi_bridge: UART RX bytes -> FIFO -> SPI master transfers; SPI responses -> UART TX. Rev 1.0
// Optional SPI-done watchdog built only when UART_SPI_BRIDGE_TIMEOUT_EN is defined.
`default_nettype none

module uart_spi_bridge #(
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic [DATA_W-1:0] spi_tx_data,
  output logic              spi_start,
  input  logic              spi_tx_done,
  input  logic [DATA_W-1:0] spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_ready,
  input  logic              clear_err,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              resp_overrun,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   spi_tx_data_q, spi_tx_data_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                resp_overrun_q, resp_overrun_d;
  logic                timeout_err_q, timeout_err_d;

  logic w_full, w_pop, w_push, w_ovf_set;
  logic w_drain, w_capture, w_ovr_set;
  logic w_timeout_fire;

  // Pointer wrap relies on FIFO_DEPTH == 2**ADDR_W.
  assign w_full    = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign w_pop     = (state_q == S_IDLE) && (count_q != '0);
  assign w_push    = uart_rx_valid && (!w_full || w_pop);
  assign w_ovf_set = uart_rx_valid && w_full && !w_pop;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    spi_tx_data_d = spi_tx_data_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      spi_tx_data_d = mem_q[rd_ptr_q];
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= uart_rx_data;
  end

`ifdef UART_SPI_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter sits at zero outside WAIT_DONE, so every entry starts a fresh count.
  assign tmo_cnt_d      = (state_q == S_WAIT) ? tmo_cnt_q + 1'b1 : '0;
  assign w_timeout_fire = (state_q == S_WAIT) && !spi_tx_done &&
                          (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign w_timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_pop) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (spi_tx_done || w_timeout_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response path: the holding register doubles as the UART TX data output.
  assign w_drain   = pending_q && uart_tx_ready;
  assign w_capture = spi_rx_valid && (!pending_q || w_drain);
  assign w_ovr_set = spi_rx_valid && pending_q && !w_drain;

  always_comb begin
    hold_d    = hold_q;
    pending_d = pending_q;
    if (w_drain) pending_d = 1'b0;
    if (w_capture) begin
      hold_d    = spi_rx_data;
      pending_d = 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as clear_err wins.
  assign overflow_d     = w_ovf_set      || (overflow_q     && !clear_err);
  assign resp_overrun_d = w_ovr_set      || (resp_overrun_q && !clear_err);
  assign timeout_err_d  = w_timeout_fire || (timeout_err_q  && !clear_err);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      spi_tx_data_q  <= '0;
      hold_q         <= '0;
      pending_q      <= 1'b0;
      overflow_q     <= 1'b0;
      resp_overrun_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      spi_tx_data_q  <= spi_tx_data_d;
      hold_q         <= hold_d;
      pending_q      <= pending_d;
      overflow_q     <= overflow_d;
      resp_overrun_q <= resp_overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign spi_tx_data   = spi_tx_data_q;
  assign spi_start     = (state_q == S_START);
  assign uart_tx_data  = hold_q;
  assign uart_tx_start = w_drain;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign resp_overrun  = resp_overrun_q;
  assign timeout_err   = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_spi_bridge.sv
// Scoreboard bench for uart_spi_bridge: stimulus pushes expected SPI/UART bytes, a monitor pops and compares.
`default_nettype none

module tb_uart_spi_bridge;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] uart_rx_data;
  logic          uart_rx_valid;
  logic [DW-1:0] spi_tx_data;
  logic          spi_start;
  logic          spi_tx_done;
  logic [DW-1:0] spi_rx_data;
  logic          spi_rx_valid;
  logic [DW-1:0] uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_ready;
  logic          clear_err;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          resp_overrun;
  logic          timeout_err;

  uart_spi_bridge #(.DATA_W(DW), .FIFO_DEPTH(8), .ADDR_W(AW), .TIMEOUT_CYCLES(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .spi_tx_data   (spi_tx_data),
    .spi_start     (spi_start),
    .spi_tx_done   (spi_tx_done),
    .spi_rx_data   (spi_rx_data),
    .spi_rx_valid  (spi_rx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_ready (uart_tx_ready),
    .clear_err     (clear_err),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .resp_overrun  (resp_overrun),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t exp_spi[$];
  exp_t exp_uart[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT strobe must match the head of its expected queue.
  exp_t m_e;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (spi_start) begin
        checks++;
        if (exp_spi.size() == 0) begin
          errors++;
          $display("FAIL spi_start_unexpected: got data %0h expected no transfer (cycle %0d)", spi_tx_data, cyc);
        end else begin
          m_e = exp_spi.pop_front();
          if (spi_tx_data !== m_e.d || (m_e.c >= 0 && cyc != m_e.c)) begin
            errors++;
            $display("FAIL spi_xfer: got %0h at cycle %0d expected %0h at cycle %0d", spi_tx_data, cyc, m_e.d, m_e.c);
          end
        end
      end
      if (uart_tx_start) begin
        checks++;
        if (exp_uart.size() == 0) begin
          errors++;
          $display("FAIL uart_tx_unexpected: got data %0h expected no send (cycle %0d)", uart_tx_data, cyc);
        end else begin
          m_e = exp_uart.pop_front();
          if (uart_tx_data !== m_e.d || (m_e.c >= 0 && cyc != m_e.c)) begin
            errors++;
            $display("FAIL uart_tx: got %0h at cycle %0d expected %0h at cycle %0d", uart_tx_data, cyc, m_e.d, m_e.c);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    step();
    spi_tx_done = 1'b1;
    step();
    spi_tx_done = 1'b0;
  endtask

  task automatic pulse_clear();
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (spi_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: spi_start got 0 expected 1 within %0d cycles", tag, limit);
    end
  endtask

  int n;
  int m;
  int t;

  initial begin
    reset         = 1'b0;
    uart_rx_data  = '0;
    uart_rx_valid = 1'b0;
    spi_tx_done   = 1'b0;
    spi_rx_data   = '0;
    spi_rx_valid  = 1'b0;
    uart_tx_ready = 1'b1;
    clear_err     = 1'b0;

    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    chk("reset_count", 32'(fifo_count), 0);
    chk("reset_spi_start", 32'(spi_start), 0);
    chk("reset_spi_tx_data", 32'(spi_tx_data), 0);
    chk("reset_uart_tx", 32'({uart_tx_start, uart_tx_data}), 0);
    chk("reset_flags", 32'({overflow, resp_overrun, timeout_err}), 0);

    // Single byte: count 1 then 0, start 2 cycles after valid, done 3 cycles after start.
    step();
    n = cyc;
    uart_rx_data  = 8'hA5;
    uart_rx_valid = 1'b1;
    exp_spi.push_back('{8'hA5, n + 2});
    step();
    uart_rx_valid = 1'b0;
    @(negedge clk);
    chk("single_count1", 32'(fifo_count), 1);
    step();
    @(negedge clk);
    chk("single_count0", 32'(fifo_count), 0);
    step();
    step();
    step();
    spi_tx_done = 1'b1;
    step();
    spi_tx_done = 1'b0;
    @(negedge clk);
    chk("single_hold_data", 32'(spi_tx_data), 32'hA5);

    // Fill: 0x01 in flight, 0x02..0x09 fill the FIFO, 0x0A overflows.
    step();
    n = cyc;
    for (int k = 1; k <= 9; k++) begin
      uart_rx_data  = 8'(k);
      uart_rx_valid = 1'b1;
      exp_spi.push_back('{8'(k), (k == 1) ? n + 2 : -1});
      step();
    end
    uart_rx_data = 8'h0A;
    @(negedge clk);
    chk("fill_count_full", 32'(fifo_count), 8);
    chk("fill_no_overflow", 32'(overflow), 0);
    step();
    uart_rx_valid = 1'b0;
    @(negedge clk);
    chk("overflow_set", 32'(overflow), 1);
    chk("overflow_count_held", 32'(fifo_count), 8);
    pulse_clear();
    @(negedge clk);
    chk("overflow_cleared", 32'(overflow), 0);

    // Push into a full FIFO during the pop cycle is accepted.
    step();
    spi_tx_done = 1'b1;
    step();
    spi_tx_done   = 1'b0;
    uart_rx_data  = 8'h0B;
    uart_rx_valid = 1'b1;
    exp_spi.push_back('{8'h0B, -1});
    step();
    uart_rx_valid = 1'b0;
    @(negedge clk);
    chk("full_pushpop_count", 32'(fifo_count), 8);
    chk("full_pushpop_no_ovf", 32'(overflow), 0);
    for (int k = 0; k < 8; k++) begin
      pulse_done();
      wait_start("drain_start", 6);
    end
    pulse_done();
    step();
    @(negedge clk);
    chk("drain_count", 32'(fifo_count), 0);

    // Response path: immediate send one cycle after valid.
    step();
    n = cyc;
    spi_rx_data  = 8'h3C;
    spi_rx_valid = 1'b1;
    exp_uart.push_back('{8'h3C, n + 1});
    step();
    spi_rx_valid = 1'b0;
    step();

    // Ready low: 0x22 dropped, only 0x11 sent.
    uart_tx_ready = 1'b0;
    spi_rx_data   = 8'h11;
    spi_rx_valid  = 1'b1;
    step();
    @(negedge clk);
    chk("ovr_not_yet", 32'(resp_overrun), 0);
    step();
    spi_rx_data = 8'h22;
    step();
    spi_rx_valid = 1'b0;
    @(negedge clk);
    chk("resp_overrun_set", 32'(resp_overrun), 1);
    step();
    m = cyc;
    uart_tx_ready = 1'b1;
    exp_uart.push_back('{8'h11, m});
    repeat (3) step();
    pulse_clear();
    @(negedge clk);
    chk("resp_overrun_cleared", 32'(resp_overrun), 0);

    // Capture during a drain keeps pending: back-to-back sends.
    step();
    n = cyc;
    spi_rx_data  = 8'h55;
    spi_rx_valid = 1'b1;
    exp_uart.push_back('{8'h55, n + 1});
    step();
    spi_rx_data = 8'h66;
    exp_uart.push_back('{8'h66, n + 2});
    step();
    spi_rx_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("no_drain_overrun", 32'(resp_overrun), 0);

    // Async reset mid-WAIT_DONE with 3 bytes queued.
    step();
    n = cyc;
    for (int k = 0; k < 4; k++) begin
      uart_rx_data  = 8'hC1 + 8'(k);
      uart_rx_valid = 1'b1;
      if (k == 0) exp_spi.push_back('{8'hC1, n + 2});
      step();
    end
    uart_rx_valid = 1'b0;
    step();
    @(negedge clk);
    chk("pre_reset_count", 32'(fifo_count), 3);
    step();
    reset = 1'b0;
    #1;
    chk("async_reset_count", 32'(fifo_count), 0);
    chk("async_reset_spi", 32'({spi_start, spi_tx_data}), 0);
    chk("async_reset_uart", 32'({uart_tx_start, uart_tx_data}), 0);
    step();
    step();
    reset = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("post_reset_count", 32'(fifo_count), 0);

    // Watchdog behaviour.
    step();
    n = cyc;
    uart_rx_data  = 8'h77;
    uart_rx_valid = 1'b1;
    exp_spi.push_back('{8'h77, n + 2});
    step();
    uart_rx_data = 8'h78;
`ifdef UART_SPI_BRIDGE_TIMEOUT_EN
    exp_spi.push_back('{8'h78, n + 2 + 1026});
`else
    exp_spi.push_back('{8'h78, -1});
`endif
    step();
    uart_rx_valid = 1'b0;
`ifdef UART_SPI_BRIDGE_TIMEOUT_EN
    t = -1;
    for (int i = 0; i < 1200 && t < 0; i++) begin
      @(negedge clk);
      if (timeout_err) t = cyc;
    end
    chk("timeout_cycle", 32'(t), 32'(n + 2 + 1025));
    wait_start("after_timeout_start", 4);
    pulse_done();
    @(negedge clk);
    chk("timeout_sticky", 32'(timeout_err), 1);
    pulse_clear();
    @(negedge clk);
    chk("timeout_cleared", 32'(timeout_err), 0);
`else
    repeat (60) step();
    @(negedge clk);
    chk("no_timeout_err", 32'(timeout_err), 0);
    chk("wait_indefinite_count", 32'(fifo_count), 1);
    pulse_done();
    wait_start("second_start", 6);
    pulse_done();
`endif
    repeat (3) step();
    @(negedge clk);
    chk("final_count", 32'(fifo_count), 0);
    chk("spi_queue_empty", 32'(exp_spi.size()), 0);
    chk("uart_queue_empty", 32'(exp_uart.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
